// File: rtl/ddc_agc_ctrl_if.sv
// Bus between the DDC output stage and the AGC controller: samples, thresholds
// and the resulting shift value.
interface ddc_agc_ctrl_if #(
  parameter int unsigned DSZ = 16
) ();
  logic                  ena;
  logic                  valid;
  logic signed [DSZ-1:0] i_in;
  logic signed [DSZ-1:0] q_in;
  logic                  sat;
  logic [DSZ-2:0]        hi_thr;
  logic [DSZ-2:0]        lo_thr;
  logic [2:0]            shf_out;
  logic                  shf_upd;
  logic [DSZ-2:0]        peak_out;
  logic                  busy;

  modport master (
    output ena, valid, i_in, q_in, sat, hi_thr, lo_thr,
    input  shf_out, shf_upd, peak_out, busy
  );

  modport slave (
    input  ena, valid, i_in, q_in, sat, hi_thr, lo_thr,
    output shf_out, shf_upd, peak_out, busy
  );
endinterface

// File: rtl/ddc_agc_ctrl.sv
// Automatic gain controller: measures peak |I|/|Q| and saturation over windows of
// valid samples and steps the 3-bit CIC output shift one notch per decision.
module ddc_agc_ctrl #(
  parameter int unsigned DSZ      = 16,
  parameter int unsigned WIN      = 10,
  parameter int unsigned HOLD     = 4,
  parameter int unsigned SHF_INIT = 7
) (
  input logic            clk,
  input logic            reset,
  ddc_agc_ctrl_if.slave  agc
);

  // HOLD <= 15, so HOLD * 2^WIN fits in WIN + 4 bits.
  localparam int unsigned CW = WIN + 4;
  localparam logic [CW-1:0] WinLast  = CW'(2 ** WIN - 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD * (2 ** WIN) - 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StHold} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DSZ-2:0] peak_q, peak_d;
  logic           sat_q, sat_d;
  logic [2:0]     shf_q, shf_d;
  logic           upd_q, upd_d;
  logic [DSZ-2:0] peak_out_q, peak_out_d;

  logic [DSZ-1:0] i_abs, q_abs;
  logic [DSZ-2:0] i_mag, q_mag, mag;
  logic [DSZ-2:0] peak_new;
  logic           sat_new, over, under;

  // Negating the most negative sample wraps back onto itself; clamp it to full scale.
  always_comb begin
    i_abs = agc.i_in[DSZ-1] ? DSZ'(-agc.i_in) : DSZ'(agc.i_in);
    q_abs = agc.q_in[DSZ-1] ? DSZ'(-agc.q_in) : DSZ'(agc.q_in);
    i_mag = i_abs[DSZ-1] ? {(DSZ-1){1'b1}} : i_abs[DSZ-2:0];
    q_mag = q_abs[DSZ-1] ? {(DSZ-1){1'b1}} : q_abs[DSZ-2:0];
    mag   = (i_mag > q_mag) ? i_mag : q_mag;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    sat_d      = sat_q;
    shf_d      = shf_q;
    upd_d      = 1'b0;
    peak_out_d = peak_out_q;

    // Window statistics including the current sample, used at the window end.
    peak_new = (mag > peak_q) ? mag : peak_q;
    sat_new  = sat_q | agc.sat;
    over     = sat_new || (peak_new > agc.hi_thr);
    under    = peak_new < agc.lo_thr;

    if (!agc.ena) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StMeasure;
          cnt_d   = '0;
          peak_d  = '0;
          sat_d   = 1'b0;
        end
        StMeasure: begin
          if (agc.valid) begin
            if (cnt_q == WinLast) begin
              peak_out_d = peak_new;
              cnt_d      = '0;
              peak_d     = '0;
              sat_d      = 1'b0;
              if (over) begin
                if (shf_q != 3'd0) begin
                  shf_d   = shf_q - 3'd1;
                  upd_d   = 1'b1;
                  state_d = StHold;
                end
              end else if (under && (shf_q != 3'd7)) begin
                shf_d   = shf_q + 3'd1;
                upd_d   = 1'b1;
                state_d = StHold;
              end
            end else begin
              cnt_d  = cnt_q + 1'b1;
              peak_d = peak_new;
              sat_d  = sat_new;
            end
          end
        end
        StHold: begin
          if (agc.valid) begin
            if (cnt_q == HoldLast) begin
              state_d = StMeasure;
              cnt_d   = '0;
              peak_d  = '0;
              sat_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      peak_q     <= '0;
      sat_q      <= 1'b0;
      shf_q      <= 3'(SHF_INIT);
      upd_q      <= 1'b0;
      peak_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      sat_q      <= sat_d;
      shf_q      <= shf_d;
      upd_q      <= upd_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign agc.shf_out  = shf_q;
  assign agc.shf_upd  = upd_q;
  assign agc.peak_out = peak_out_q;
  assign agc.busy     = (state_q != StIdle);

endmodule
